// File: rtl/stall_arb.sv
// Round-robin arbiter feeding one registered output slot with per-requester stall back-pressure.
// Define STALL_ARB_LOCK_EN to hold a grant across a packet until the beat with req_last=1.
module stall_arb #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_stalled,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  input  logic                 out_stalled,
  output logic [IDW-1:0]       grant_id
);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   rr_win;
  logic             rr_hit;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   ptr_nxt;
  logic             can_accept;
  logic             xfer;
  logic             ends_grant;
  logic [WIDTH-1:0] win_data;
  logic             win_last;
  int unsigned      scan_idx;

  assign can_accept = !out_valid || !out_stalled;

  // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-2 N never aliases.
  always_comb begin
    rr_win   = ptr;
    rr_hit   = 1'b0;
    scan_idx = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!rr_hit && req_valid[scan_idx]) begin
        rr_hit = 1'b1;
        rr_win = IDW'(scan_idx);
      end
    end
  end

`ifdef STALL_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t         state, state_nxt;
  logic [IDW-1:0] lock_id, lock_id_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    case (state)
      IDLE: begin
        if (xfer && !win_last) begin
          state_nxt   = LOCKED;
          lock_id_nxt = winner;
        end
      end
      LOCKED: begin
        if (xfer && win_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign winner     = (state == LOCKED) ? lock_id : rr_win;
  assign ends_grant = win_last;
`else
  assign winner     = rr_win;
  assign ends_grant = 1'b1;
`endif

  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (IDW'(i) == winner) begin
        win_data = req_data[i*WIDTH +: WIDTH];
        win_last = req_last[i];
      end
    end
  end

  always_comb begin
    req_stalled = '1;
    for (int unsigned i = 0; i < N; i++) begin
      req_stalled[i] = !((IDW'(i) == winner) && can_accept);
    end
  end

  assign xfer    = req_valid[winner] && can_accept;
  assign ptr_nxt = (winner == IDW'(N-1)) ? '0 : winner + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      grant_id  <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_last  <= win_last;
        grant_id  <= winner;
        if (ends_grant) ptr <= ptr_nxt;
      end else if (can_accept) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  a_onehot_grant: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(~req_stalled & req_valid));
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && out_stalled) |=> ($stable(out_data) && $stable(out_last) && $stable(grant_id)));
  a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> !$isunknown({out_data, out_last, grant_id}));
`endif

endmodule

// File: tb/tb_stall_arb.sv
// Self-checking bench for stall_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_stall_arb;
  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;
`ifdef STALL_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N*WIDTH-1:0]   req_data;
  logic [N-1:0]         req_last;
  logic [N-1:0]         req_stalled;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic                 out_stalled;
  logic [IDW-1:0]       grant_id;

  int checks = 0;
  int errors = 0;

  stall_arb #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_stalled(req_stalled),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_stalled(out_stalled), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int          m_ptr;
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_last;
  int          m_gid;
  bit          m_locked;
  int          m_lock;

  function automatic int m_winner();
    if (m_locked) return m_lock;
    for (int d = 0; d < N; d++)
      if (req_valid[(m_ptr + d) % N]) return (m_ptr + d) % N;
    return m_ptr;
  endfunction

  function automatic logic [N-1:0] m_stalled();
    if (!m_valid || !out_stalled) return ~(4'b0001 << m_winner());
    return '1;
  endfunction

  task automatic m_update();
    int w;
    bit accept;
    w = m_winner();
    accept = !m_valid || !out_stalled;
    if (accept && req_valid[w]) begin
      m_valid = 1'b1;
      m_data  = req_data[w*WIDTH +: WIDTH];
      m_last  = req_last[w];
      m_gid   = w;
      if (LOCK) begin
        if (!m_locked && !req_last[w]) begin
          m_locked = 1'b1;
          m_lock   = w;
        end else if (m_locked && req_last[w]) begin
          m_locked = 1'b0;
        end
      end
      if (!LOCK || req_last[w]) m_ptr = (w + 1) % N;
    end else if (accept) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    out_stalled = 1'b0;
    #3;
    @(negedge clk);
    rst_n    = 1'b1;
    m_ptr    = 0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_last   = 1'b0;
    m_gid    = 0;
    m_locked = 1'b0;
    m_lock   = 0;
  endtask

  task automatic test_reset();
    logic [N-1:0] rv;
    logic [N-1:0] exp_st;
    rst_n = 1'b0;
    req_last = '0;
    for (int it = 0; it < 4; it++) begin
      req_valid   = N'($urandom);
      req_data    = {$urandom, $urandom, $urandom, $urandom};
      out_stalled = 1'($urandom);
      #7;
      rv = req_valid;
      exp_st = (rv == '0) ? 4'b1110 : ~(rv & (~rv + 4'b0001));
      checks++;
      if (out_valid !== 1'b0 || grant_id !== '0 || out_data !== '0) begin
        errors++;
        $display("FAIL reset_outs got v=%b g=%0d d=%h exp v=0 g=0 d=0", out_valid, grant_id, out_data);
      end
      checks++;
      if (req_stalled !== exp_st) begin
        errors++;
        $display("FAIL reset_stalled got %b exp %b (req_valid %b)", req_stalled, exp_st, rv);
      end
    end
    @(negedge clk);
    rst_n       = 1'b1;
    out_stalled = 1'b0;
    req_valid   = 4'b0100;
    req_last    = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 32'hC0DE_0002;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early got out_valid=%b exp 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || grant_id !== 2'd2 || out_data !== 32'hC0DE_0002) begin
      errors++;
      $display("FAIL reset_first_beat got v=%b g=%0d d=%h exp v=1 g=2 d=c0de0002", out_valid, grant_id, out_data);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = '1;
    req_last  = '1;
    for (int i = 0; i < N; i++) req_data[i*WIDTH +: WIDTH] = 32'h100 + i;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (req_stalled !== ~(4'b0001 << (k % N))) begin
        errors++;
        $display("FAIL fair_stalled[%0d] got %b exp %b", k, req_stalled, ~(4'b0001 << (k % N)));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || grant_id !== IDW'(k % N) || out_data !== 32'h100 + (k % N)) begin
        errors++;
        $display("FAIL fair_beat[%0d] got v=%b g=%0d d=%h exp v=1 g=%0d d=%h",
                 k, out_valid, grant_id, out_data, k % N, 32'h100 + (k % N));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001;
    req_last  = '1;
    req_data[0 +: WIDTH] = 32'hA5;
    tick();
    for (int i = 0; i < N; i++) req_data[i*WIDTH +: WIDTH] = 32'h200 + i;
    req_valid   = '1;
    out_stalled = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (req_stalled !== 4'b1111) begin
        errors++;
        $display("FAIL bp_stalled[%0d] got %b exp 1111", k, req_stalled);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5 || grant_id !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h g=%0d exp v=1 d=a5 g=0", k, out_valid, out_data, grant_id);
      end
    end
    out_stalled = 1'b0;
    #1;
    checks++;
    if (req_stalled !== 4'b1101) begin
      errors++;
      $display("FAIL bp_release_stalled got %b exp 1101", req_stalled);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || grant_id !== 2'd1 || out_data !== 32'h201) begin
      errors++;
      $display("FAIL bp_release_beat got v=%b g=%0d d=%h exp v=1 g=1 d=201", out_valid, grant_id, out_data);
    end
  endtask

  task automatic test_sparse_wrap();
    int exp_g [4] = '{3, 1, 3, 2};
    do_reset();
    req_last = '1;
    for (int i = 0; i < N; i++) req_data[i*WIDTH +: WIDTH] = 32'h300 + i;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_valid = 4'b0100;
      tick();
      checks++;
      if (out_valid !== 1'b1 || grant_id !== IDW'(exp_g[k]) || out_data !== 32'h300 + exp_g[k]) begin
        errors++;
        $display("FAIL sparse[%0d] got v=%b g=%0d d=%h exp v=1 g=%0d", k, out_valid, grant_id, out_data, exp_g[k]);
      end
    end
  endtask

`ifdef STALL_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req_data[0 +: WIDTH]     = 32'h10;
    req_data[WIDTH +: WIDTH] = 32'h20;
    req_valid = 4'b0011;
    req_last  = 4'b0010;
    tick();
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_stalled !== 4'b1110) begin
      errors++;
      $display("FAIL lock_bubble_stalled got %b exp 1110", req_stalled);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lock_bubble_out got v=%b exp 0", out_valid);
    end
    req_valid = 4'b0011;
    tick();
    req_last = 4'b0011;
    #1;
    checks++;
    if (req_stalled !== 4'b1110) begin
      errors++;
      $display("FAIL lock_last_stalled got %b exp 1110", req_stalled);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || grant_id !== 2'd0 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL lock_last_beat got v=%b g=%0d l=%b exp v=1 g=0 l=1", out_valid, grant_id, out_last);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || grant_id !== 2'd1 || out_data !== 32'h20) begin
      errors++;
      $display("FAIL lock_next_grant got v=%b g=%0d d=%h exp v=1 g=1 d=20", out_valid, grant_id, out_data);
    end
  endtask

  task automatic test_midpacket_reset();
    do_reset();
    req_valid = 4'b0011;
    req_last  = 4'b0000;
    req_data[WIDTH +: WIDTH] = 32'h21;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL midreset_outs got v=%b g=%0d exp v=0 g=0", out_valid, grant_id);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    #1;
    checks++;
    if (req_stalled !== 4'b1101) begin
      errors++;
      $display("FAIL midreset_stalled got %b exp 1101", req_stalled);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || grant_id !== 2'd1 || out_data !== 32'h21) begin
      errors++;
      $display("FAIL midreset_grant got v=%b g=%0d d=%h exp v=1 g=1 d=21", out_valid, grant_id, out_data);
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] exp_st;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      req_valid   = N'($urandom);
      req_last    = N'($urandom);
      req_data    = {$urandom, $urandom, $urandom, $urandom};
      out_stalled = ($urandom_range(0, 2) == 0);
      #1;
      exp_st = m_stalled();
      checks++;
      if (req_stalled !== exp_st) begin
        errors++;
        $display("FAIL rand_stalled[%0d] got %b exp %b", k, req_stalled, exp_st);
      end
      checks++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("FAIL rand_valid[%0d] got %b exp %b", k, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (out_data !== m_data || out_last !== m_last || grant_id !== IDW'(m_gid)) begin
          errors++;
          $display("FAIL rand_beat[%0d] got d=%h l=%b g=%0d exp d=%h l=%b g=%0d",
                   k, out_data, out_last, grant_id, m_data, m_last, m_gid);
        end
      end
      m_update();
      tick();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    out_stalled = 1'b0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_sparse_wrap();
`ifdef STALL_ARB_LOCK_EN
    test_lock();
    test_midpacket_reset();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
